seq_det_prog: RTL and testbench

- Parametrised successor to the fixed 4-bit "1001" serial sequence detector.
- Detects a runtime-loadable PAT_LEN-bit pattern on a serial bit stream, with:
  - a valid qualifier on the input stream,
  - selectable overlapping or non-overlapping detection,
  - a saturating match counter.
- Sits on a serial input stream as a Moore-style detector, feeding status/interrupt logic.

---
 rtl/seq_det_prog.sv | 74 +++++++
 tb/tb_seq_det_prog.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector: runtime-loadable pattern, valid-qualified
// input, overlapping or non-overlapping detection and a saturating match counter.
module seq_det_prog #(
    parameter int                 PAT_LEN     = 4,
    parameter logic [PAT_LEN-1:0] DEFAULT_PAT = PAT_LEN'(4'b1001),
    parameter int                 CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seqIn,
    input  logic               seqValid,
    input  logic               overlap,
    input  logic               patLoad,
    input  logic [PAT_LEN-1:0] patIn,
    input  logic               cntClr,
    output logic               detOut,
    output logic [CNT_W-1:0]   matchCnt
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] pattern;
    logic [PAT_LEN-1:0] history;
    logic [FILL_W-1:0]  fill;

    logic               accept;
    logic [PAT_LEN-1:0] hist_next;
    logic [FILL_W-1:0]  fill_next;
    logic               match;

    // A load always wins, so a bit arriving in the load cycle is never accepted.
    always_comb begin
        accept    = seqValid && !patLoad;
        hist_next = {history[PAT_LEN-2:0], seqIn};
        fill_next = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
        match     = accept && (fill_next == FILL_FULL) && (hist_next == pattern);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern <= DEFAULT_PAT;
            history <= '0;
            fill    <= '0;
        end else if (patLoad) begin
            pattern <= patIn;
            history <= '0;
            fill    <= '0;
        end else if (accept) begin
            history <= hist_next;
            // Non-overlapping mode demands a full set of fresh bits after each hit.
            fill    <= (match && !overlap) ? '0 : fill_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            detOut <= 1'b0;
        end else begin
            detOut <= match;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            matchCnt <= '0;
        end else if (cntClr) begin
            matchCnt <= '0;
        end else if (match && (matchCnt != {CNT_W{1'b1}})) begin
            matchCnt <= matchCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_det_prog.sv
// Bench for seq_det_prog: directed scenarios plus a randomized run checked
// against a queue-based reference model; a second instance uses a 2-bit counter.
module tb_seq_det_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       seq_in = 1'b0;
    logic       seq_valid = 1'b0;
    logic       ovl = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic       cnt_clr = 1'b0;
    logic       det;
    logic [7:0] cnt;
    logic       det2;
    logic [1:0] cnt2;

    int errors = 0;
    int checks = 0;

    // Reference model state: the accepted bits since the last restart.
    bit         q[$];
    logic [3:0] m_pat;
    logic       m_det;
    int         m_cnt;
    int         m_cnt2;

    seq_det_prog dut (
        .clk(clk), .rst(rst), .seqIn(seq_in), .seqValid(seq_valid),
        .overlap(ovl), .patLoad(pat_load), .patIn(pat_in), .cntClr(cnt_clr),
        .detOut(det), .matchCnt(cnt)
    );

    seq_det_prog #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .seqIn(seq_in), .seqValid(seq_valid),
        .overlap(ovl), .patLoad(pat_load), .patIn(pat_in), .cntClr(cnt_clr),
        .detOut(det2), .matchCnt(cnt2)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required finish before limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic model_reset();
        q.delete();
        m_pat  = 4'b1001;
        m_det  = 1'b0;
        m_cnt  = 0;
        m_cnt2 = 0;
    endtask

    // One clock of the behavioural model: a match is the last four accepted
    // bits, with at least four accepted since the last restart, equal to the pattern.
    task automatic model_step(input logic v, input logic b, input logic ov,
                              input logic ld, input logic [3:0] pi, input logic clr);
        logic [3:0] val;
        bit matched;
        matched = 1'b0;
        if (ld) begin
            m_pat = pi;
            q.delete();
        end else if (v) begin
            q.push_back(b);
            if (q.size() > 4) void'(q.pop_front());
            if (q.size() == 4) begin
                val = 4'b0000;
                foreach (q[i]) val = {val[2:0], q[i]};
                matched = (val == m_pat);
            end
            if (matched && !ov) q.delete();
        end
        m_det = matched;
        if (clr) begin
            m_cnt  = 0;
            m_cnt2 = 0;
        end else if (matched) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    task automatic tick(input logic v, input logic b, input logic ov,
                        input logic ld, input logic [3:0] pi, input logic clr);
        seq_valid = v;
        seq_in    = b;
        ovl       = ov;
        pat_load  = ld;
        pat_in    = pi;
        cnt_clr   = clr;
        @(posedge clk);
        model_step(v, b, ov, ld, pi, clr);
        #1;
    endtask

    task automatic do_reset();
        seq_valid = 1'b0;
        pat_load  = 1'b0;
        cnt_clr   = 1'b0;
        rst       = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (det !== 1'b0 || cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_idle: det=%b cnt=%0d, required det=0 cnt=0", det, cnt);
        end
        tick(1, 1, 1, 0, 0, 0);
        tick(1, 0, 1, 0, 0, 0);
        tick(1, 0, 1, 0, 0, 0);
        tick(1, 1, 1, 0, 0, 0);
        checks++;
        if (det !== 1'b1 || cnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL reset_prematch: det=%b cnt=%0d, required det=1 cnt=1", det, cnt);
        end
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (det !== 1'b0 || cnt !== 8'd0 || cnt2 !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_async: det=%b cnt=%0d cnt2=%0d, required all 0", det, cnt, cnt2);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_stream7(input logic ov, input logic [6:0] want, input int want_cnt,
                               input string name);
        logic [6:0] s;
        s = 7'b1001001;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            tick(1, s[6-i], ov, 0, 0, 0);
            checks++;
            if (det !== want[6-i]) begin
                errors++;
                $display("[TB] FAIL %s_det bit%0d: det=%b, required %b", name, i + 1, det, want[6-i]);
            end
        end
        tick(0, 0, ov, 0, 0, 0);
        checks++;
        if (cnt !== 8'(want_cnt) || det !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_cnt: cnt=%0d det=%b, required cnt=%0d det=0", name, cnt, det, want_cnt);
        end
    endtask

    task automatic test_overlap();
        run_stream7(1'b1, 7'b0001001, 2, "overlap");
    endtask

    task automatic test_non_overlap();
        run_stream7(1'b0, 7'b0001000, 1, "nonoverlap");
    endtask

    task automatic test_gaps();
        logic [3:0] s;
        s = 4'b1001;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1, s[3-i], 1, 0, 0, 0);
            checks++;
            if (det !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL gaps_bit%0d: det=%b, required %b", i + 1, det, (i == 3));
            end
            for (int g = 0; g < 3; g++) begin
                tick(0, ~s[3-i], 1, 0, 0, 0);
                checks++;
                if (det !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL gaps_idle%0d_%0d: det=%b, required 0", i + 1, g, det);
                end
            end
        end
        checks++;
        if (cnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL gaps_cnt: cnt=%0d, required 1", cnt);
        end
    endtask

    task automatic test_zero_pattern();
        do_reset();
        tick(1, 0, 1, 1, 4'b0000, 0);
        checks++;
        if (det !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_load: det=%b, required 0", det);
        end
        for (int i = 1; i <= 7; i++) begin
            tick(1, 0, 1, 0, 0, 0);
            checks++;
            if (det !== (i >= 4)) begin
                errors++;
                $display("[TB] FAIL zero_bit%0d: det=%b, required %b", i, det, (i >= 4));
            end
        end
        checks++;
        if (cnt !== 8'd4) begin
            errors++;
            $display("[TB] FAIL zero_cnt: cnt=%0d, required 4", cnt);
        end
    endtask

    task automatic test_saturation();
        int want2;
        do_reset();
        tick(0, 0, 1, 1, 4'b1111, 0);
        for (int i = 1; i <= 8; i++) begin
            tick(1, 1, 1, 0, 0, 0);
            want2 = (i < 4) ? 0 : ((i - 3 > 3) ? 3 : i - 3);
            checks++;
            if (cnt2 !== 2'(want2) || cnt !== 8'((i < 4) ? 0 : i - 3)) begin
                errors++;
                $display("[TB] FAIL sat_bit%0d: cnt2=%0d cnt=%0d, required cnt2=%0d cnt=%0d",
                         i, cnt2, cnt, want2, (i < 4) ? 0 : i - 3);
            end
        end
        tick(1, 1, 1, 0, 0, 1);
        checks++;
        if (cnt2 !== 2'd0 || cnt !== 8'd0 || det !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_clear: cnt2=%0d cnt=%0d det=%b, required 0 0 1", cnt2, cnt, det);
        end
    endtask

    task automatic test_reset_midstream();
        logic [3:0] s;
        s = 4'b1001;
        do_reset();
        tick(0, 0, 1, 1, 4'b0110, 0);
        tick(1, 1, 1, 0, 0, 0);
        tick(1, 0, 1, 0, 0, 0);
        tick(1, 0, 1, 0, 0, 0);
        do_reset();
        tick(1, 1, 1, 0, 0, 0);
        checks++;
        if (det !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_first: det=%b, required 0", det);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1, s[3-i], 1, 0, 0, 0);
            checks++;
            if (det !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL midrst_bit%0d: det=%b, required %b", i + 1, det, (i == 3));
            end
        end
    endtask

    task automatic test_random();
        logic v, b, ov, ld, clr;
        logic [3:0] pi;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            v   = ($urandom_range(0, 9) < 7);
            b   = 1'($urandom_range(0, 1));
            ov  = 1'($urandom_range(0, 1));
            ld  = ($urandom_range(0, 49) == 0);
            clr = ($urandom_range(0, 39) == 0);
            pi  = 4'($urandom_range(0, 15));
            tick(v, b, ov, ld, pi, clr);
            checks++;
            if (det !== m_det || cnt !== 8'(m_cnt) || det2 !== m_det || cnt2 !== 2'(m_cnt2)) begin
                errors++;
                $display("[TB] FAIL random_cyc%0d: det=%b cnt=%0d det2=%b cnt2=%0d, required det=%b cnt=%0d cnt2=%0d",
                         n, det, cnt, det2, cnt2, m_det, m_cnt, m_cnt2);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_overlap();
        test_non_overlap();
        test_gaps();
        test_zero_pattern();
        test_saturation();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
